weight_stream_reader: RTL

//  Read-side sequencer for one single-port weight BRAM (negedge-read, EN/WE/ADDR/DI/DO).
//  On START it issues DEPTH sequential reads from address 0 and streams words to the neuron MAC

---
 rtl/weight_stream_reader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/weight_stream_reader.sv
// weight_stream_reader
//   Read-side sequencer for a single-port weight BRAM with a negedge read port.
//   On an accepted START it issues DEPTH sequential reads from address 0 and
//   streams the words to the neuron MAC over a valid/ready handshake. A 2-entry
//   output buffer absorbs the one-cycle read latency and MAC backpressure.
//   The BRAM is never written.
//
//   Optional feature: define WSR_CHECKSUM_EN to add o_checksum, the XOR of every
//   word handshaken in the current pass (cleared on START accept).
`timescale 1ns/1ps

module weight_stream_reader #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_en,
  output logic              o_bram_we,
  input  logic [DATA_W-1:0] i_bram_do,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic              o_w_last,
  output logic [ADDR_W-1:0] o_w_idx
`ifdef WSR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  // One extra bit so that DEPTH == 2**ADDR_W is reachable without wrapping.
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // One buffered word together with where it came from.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } entry_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [CNT_W-1:0]  r_rd_ptr;
  logic              r_bram_en;
  logic [ADDR_W-1:0] r_bram_addr;

  logic [1:0]        r_occ;
  entry_t            r_head;
  entry_t            r_tail;
  entry_t            w_new;

  logic              w_start_acc;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_level;

  // A read issued on the previous edge returns its data on this edge, so the
  // registered enable doubles as the "one read in flight" flag.
  assign w_push = r_bram_en;

  // The in-flight read is tagged with the address it was issued to.
  assign w_new = {i_bram_do, r_bram_addr, (r_bram_addr == LAST_IDX)};

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, handshake and read-issue decisions.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_issue      = 1'b0;
    w_pop        = (r_occ != 2'd0) && i_w_ready;
    // Buffer occupancy plus in-flight read after this cycle's pop; a new read
    // may only be issued if the result still leaves room for it.
    w_level      = {1'b0, r_occ} + {2'b00, r_bram_en} - {2'b00, w_pop};
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_acc  = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = (r_rd_ptr < DEPTH_C) && (w_level < 3'd2);
        if (w_pop && r_head.last) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Read pointer and BRAM port registers; the address holds after the last read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr    <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
    end else begin
      r_bram_en <= w_issue;
      if (w_start_acc) begin
        r_rd_ptr <= '0;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + CNT_W'(1);
        r_bram_addr <= r_rd_ptr[ADDR_W-1:0];
      end
    end
  end

  // Two-entry output FIFO; the head entry drives the MAC interface.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && !w_pop) begin
        if (r_occ == 2'd0) begin
          r_head <= w_new;
        end else begin
          r_tail <= w_new;
        end
        r_occ <= r_occ + 2'd1;
      end else if (!w_push && w_pop) begin
        // With one entry the head is simply left stale (valid drops).
        if (r_occ == 2'd2) begin
          r_head <= r_tail;
        end
        r_occ <= r_occ - 2'd1;
      end else if (w_push && w_pop) begin
        // Occupancy stays the same; the issue rule keeps this at one entry,
        // the two-entry branch only keeps the FIFO coherent.
        if (r_occ == 2'd1) begin
          r_head <= w_new;
        end else begin
          r_head <= r_tail;
          r_tail <= w_new;
        end
      end
    end
  end

`ifdef WSR_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running XOR of every handshaken word in the current pass.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum ^ r_head.data;
    end
  end

  assign o_checksum = r_checksum;
`endif

  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_FIN);
  assign o_bram_en   = r_bram_en;
  assign o_bram_addr = r_bram_addr;
  assign o_bram_we   = 1'b0;
  assign o_w_valid   = (r_occ != 2'd0);
  assign o_w_data    = r_head.data;
  assign o_w_idx     = r_head.idx;
  assign o_w_last    = r_head.last & o_w_valid;

endmodule
